// File: rtl/fifo_pkg.sv
// Shared definitions for the virtual-channel FIFO and the router around it.
//   clog2()   : ceiling log2, usable in parameter expressions
//   FlitWidth : flit width shared with the router datapath
//   Def*      : default FIFO geometry
package fifo_pkg;

    localparam int unsigned FlitWidth = 32;
    localparam int unsigned DefWidth  = FlitWidth;
    localparam int unsigned DefDepth  = 8;
    localparam int unsigned DefNumVc  = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_vc_ptr.sv
// Pointer pair and status flags for one FIFO channel.
//   clk, rst        : clock, synchronous active-high reset
//   push_i, pop_i   : increment strobes for write/read pointer (already qualified)
//   wptr_o, rptr_o  : pointers, AW+1 bits, MSB is the wrap bit
//   full_o, empty_o : channel status
//   count_o         : occupancy, 0..DEPTH
module fifo_vc_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    output logic [AW:0] wptr_o,
    output logic [AW:0] rptr_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    // Same slot but different lap means the channel holds DEPTH entries.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // Modulo subtraction handles the wrap bit naturally.
    assign count_o = wptr_q - rptr_q;

endmodule

// File: rtl/fifo_vc_buffer.sv
// Multi-channel (virtual-channel) FIFO for a NoC router input port.
// NUM_VC FIFOs share one storage array with one write and one read port.
//   clk, rst        : clock, synchronous active-high reset
//   wen, wvc, wdata : push request, target channel, flit
//   ren, rvc        : pop request, source channel
//   rdata, rvalid   : popped flit, registered (valid the cycle after the pop)
//   full, empty     : per-channel status
//   count           : per-channel occupancy, channel i at [i*(AW+1) +: AW+1]
//   err_ovf/err_udf : sticky rejected-push / rejected-pop flags, cleared by rst only
module fifo_vc_buffer
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned NUM_VC = DefNumVc,
    localparam int unsigned AW    = clog2(DEPTH),
    localparam int unsigned VW    = (NUM_VC > 1) ? clog2(NUM_VC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [VW-1:0]            wvc,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     ren,
    input  logic [VW-1:0]            rvc,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic [NUM_VC-1:0]        full,
    output logic [NUM_VC-1:0]        empty,
    output logic [NUM_VC*(AW+1)-1:0] count,
    output logic                     err_ovf,
    output logic                     err_udf
);

    // Status vectors padded to every encodable channel index, so an
    // out-of-range index reads as full and empty instead of X.
    localparam int unsigned NumSlots = 1 << VW;

    logic [WIDTH-1:0]    mem [NUM_VC*DEPTH];
    logic [AW:0]         wptr [NUM_VC];
    logic [AW:0]         rptr [NUM_VC];
    logic [NUM_VC-1:0]   push_inc, pop_inc;
    logic [NumSlots-1:0] full_ext, empty_ext;
    logic [AW-1:0]       wptr_sel, rptr_sel;
    logic [VW+AW-1:0]    waddr, raddr;
    logic                wvc_ok, rvc_ok;
    logic                push_ok, pop_ok;

    assign wvc_ok = (32'(wvc) < NUM_VC);
    assign rvc_ok = (32'(rvc) < NUM_VC);

    always_comb begin
        full_ext                = '1;
        empty_ext               = '1;
        full_ext[NUM_VC-1:0]    = full;
        empty_ext[NUM_VC-1:0]   = empty;
        wptr_sel                = '0;
        rptr_sel                = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (wvc == VW'(i)) wptr_sel = wptr[i][AW-1:0];
            if (rvc == VW'(i)) rptr_sel = rptr[i][AW-1:0];
        end
    end

    // No bypass: an empty channel cannot be popped even if pushed this cycle.
    assign pop_ok  = ren && rvc_ok && !empty_ext[rvc];
    // A full channel may accept a push when the same channel is popped this cycle.
    assign push_ok = wen && wvc_ok && (!full_ext[wvc] || (pop_ok && (rvc == wvc)));

    assign waddr = {wvc, wptr_sel};
    assign raddr = {rvc, rptr_sel};

    for (genvar g = 0; g < NUM_VC; g++) begin : gen_vc
        assign push_inc[g] = push_ok && (wvc == VW'(g));
        assign pop_inc[g]  = pop_ok  && (rvc == VW'(g));

        fifo_vc_ptr #(
            .DEPTH (DEPTH)
        ) u_ptr (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push_inc[g]),
            .pop_i   (pop_inc[g]),
            .wptr_o  (wptr[g]),
            .rptr_o  (rptr[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .count_o (count[g*(AW+1) +: AW+1])
        );
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of mem returns the pre-write value on a same-slot collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= pop_ok;
            if (pop_ok) rdata <= mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            err_ovf <= err_ovf | (wen && !push_ok);
            err_udf <= err_udf | (ren && !pop_ok);
        end
    end

endmodule

// File: tb/tb_fifo_vc_buffer.sv
module tb_fifo_vc_buffer;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 8;
    localparam int NUM_VC = 2;
    localparam int AW     = 3;
    localparam int VW     = 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wen, ren;
    logic [VW-1:0]            wvc, rvc;
    logic [WIDTH-1:0]         wdata, rdata;
    logic                     rvalid;
    logic [NUM_VC-1:0]        full, empty;
    logic [NUM_VC*(AW+1)-1:0] count;
    logic                     err_ovf, err_udf;

    fifo_vc_buffer #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NUM_VC (NUM_VC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .wvc     (wvc),
        .wdata   (wdata),
        .ren     (ren),
        .rvc     (rvc),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .err_ovf (err_ovf),
        .err_udf (err_udf)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one queue per channel plus the registered outputs.
    logic [WIDTH-1:0] q [NUM_VC][$];
    logic [WIDTH-1:0] m_rdata;
    logic             m_rvalid, m_ovf, m_udf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " rvalid"}, 64'(rvalid), 64'(m_rvalid));
        chk({tag, " rdata"}, 64'(rdata), 64'(m_rdata));
        chk({tag, " err_ovf"}, 64'(err_ovf), 64'(m_ovf));
        chk({tag, " err_udf"}, 64'(err_udf), 64'(m_udf));
        for (int v = 0; v < NUM_VC; v++) begin
            chk($sformatf("%s empty[%0d]", tag, v), 64'(empty[v]), 64'(q[v].size() == 0));
            chk($sformatf("%s full[%0d]", tag, v), 64'(full[v]), 64'(q[v].size() == DEPTH));
            chk($sformatf("%s count[%0d]", tag, v), 64'(count[v*(AW+1) +: AW+1]),
                64'(q[v].size()));
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NUM_VC; v++) q[v].delete();
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
    endtask

    // One clock with the given requests, then model update and full check.
    task automatic step(input string tag, input bit w, input int wv, input logic [WIDTH-1:0] wd,
                        input bit r, input int rv);
        bit pop_ok, push_ok;
        rst   = 1'b0;
        wen   = w;
        wvc   = wv[VW-1:0];
        wdata = wd;
        ren   = r;
        rvc   = rv[VW-1:0];
        pop_ok  = r && (q[rv].size() > 0);
        push_ok = w && ((q[wv].size() < DEPTH) || (pop_ok && rv == wv));
        @(posedge clk);
        #1;
        if (pop_ok) begin
            m_rdata  = q[rv].pop_front();
            m_rvalid = 1'b1;
        end else begin
            m_rvalid = 1'b0;
        end
        if (push_ok) q[wv].push_back(wd);
        if (w && !push_ok) m_ovf = 1'b1;
        if (r && !pop_ok)  m_udf = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        check_all(tag);
    endtask

    // Reset with a pending pop request to show reset overrides it.
    task automatic do_reset(input string tag, input bit with_pop);
        rst = 1'b1;
        ren = with_pop;
        rvc = '0;
        wen = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ren = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        rst   = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        wvc   = '0;
        rvc   = '0;
        wdata = '0;
        model_reset();

        // 1. Reset, then idle
        do_reset("reset", 1'b0);
        step("idle", 1'b0, 0, '0, 1'b0, 0);

        // 2. Fill vc0 then drain it
        for (int i = 0; i < 8; i++) step("fill0", 1'b1, 0, 32'hA0 + 32'(i), 1'b0, 0);
        chk("full0 after 8", 64'(full[0]), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step("drain0", 1'b0, 0, '0, 1'b1, 0);
            chk("drain0 order", 64'(rdata), 64'(32'hA0 + 32'(i)));
        end
        step("drain0 idle", 1'b0, 0, '0, 1'b0, 0);

        // 3. Interleave traffic across channels; pointers lap past DEPTH
        for (int i = 0; i < 4; i++) step("pre0", 1'b1, 0, 32'hC0 + 32'(i), 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step("ilv a", 1'b1, 1, 32'hB0 + 32'(i), 1'b1, 0);
            else            step("ilv b", 1'b1, 0, 32'hD0 + 32'(i), 1'b1, 1);
        end

        // 4. Simultaneous push and pop on a full channel
        do_reset("reset4", 1'b0);
        for (int i = 0; i < 8; i++) step("fill4", 1'b1, 0, 32'h40 + 32'(i), 1'b0, 0);
        step("full rw", 1'b1, 0, 32'hCC, 1'b1, 0);
        chk("full rw rdata", 64'(rdata), 64'h40);
        chk("full rw count", 64'(count[AW:0]), 64'd8);
        chk("full rw ovf", 64'(err_ovf), 64'd0);

        // 5. Overflow and underflow, sticky until reset
        for (int i = 0; i < 8; i++) step("fill5", 1'b1, 1, 32'h50 + 32'(i), 1'b0, 1);
        step("ovf", 1'b1, 1, 32'hEE, 1'b0, 0);
        chk("ovf flag", 64'(err_ovf), 64'd1);
        for (int i = 0; i < 8; i++) step("drain5", 1'b0, 0, '0, 1'b1, 0);
        step("udf", 1'b0, 0, '0, 1'b1, 0);
        chk("udf flag", 64'(err_udf), 64'd1);
        chk("udf rvalid", 64'(rvalid), 64'd0);
        for (int i = 0; i < 3; i++) step("sticky", 1'b0, 0, '0, 1'b0, 0);

        // 6. Reset mid-burst with a pop in flight
        do_reset("reset6a", 1'b0);
        for (int i = 0; i < 5; i++) step("burst6", 1'b1, 0, 32'h60 + 32'(i), 1'b0, 0);
        ren = 1'b1;
        rvc = '0;
        do_reset("reset6b", 1'b1);
        chk("rst count0", 64'(count[AW:0]), 64'd0);
        chk("rst rdata", 64'(rdata), 64'd0);
        step("push11", 1'b1, 0, 32'h11, 1'b0, 0);
        step("pop11", 1'b0, 0, '0, 1'b1, 0);
        chk("pop11 rdata", 64'(rdata), 64'h11);

        // Randomized traffic against the queue model
        do_reset("reset rnd", 1'b0);
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 3) != 0), int'($urandom_range(0, NUM_VC - 1)),
                 WIDTH'($urandom), ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, NUM_VC - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
